pipe_redirect_arb: RTL and testbench

- Pipeline redirect/stall arbiter for the 5-stage RV32 core; replaces the single-source jump/flush register stage.
- Accepts redirect requests from EX (branch/jump), the trap unit (exception/mret) and, optionally, the interrupt controller.
- Accepts hold requests from the load-use hazard detector and the data bus.
- Selects one redirect, sequences the PC redirect plus a multi-cycle flush drain, and drives per-stage stall/flush controls.

---
 rtl/pipe_redirect_arb_pkg.sv | 31 +++
 rtl/pipe_redirect_arb_prio_sel.sv | 37 +++
 rtl/pipe_redirect_arb.sv | 182 ++++++++++++++++++
 tb/tb_pipe_redirect_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_redirect_arb_pkg.sv
// Shared types for the pipeline redirect/stall arbiter: FSM states, redirect source codes,
// and a helper that ranks redirect sources by priority.
package pipe_redirect_arb_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StIssue = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcJump = 2'd1,
    SrcTrap = 2'd2,
    SrcIrq  = 2'd3
  } redir_src_e;

  localparam int unsigned CntW = 4;

  // Higher value wins: trap > jump > irq > none.
  function automatic logic [1:0] src_rank(redir_src_e s);
    case (s)
      SrcTrap: src_rank = 2'd3;
      SrcJump: src_rank = 2'd2;
      SrcIrq:  src_rank = 2'd1;
      default: src_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_redirect_arb_prio_sel.sv
// Combinational 3-way redirect priority select (trap > jump > irq).
module pipe_redirect_arb_prio_sel
  import pipe_redirect_arb_pkg::*;
#(
  parameter int unsigned AddrW = 32
) (
  input  logic             jump_en,
  input  logic [AddrW-1:0] jump_addr,
  input  logic             trap_req,
  input  logic [AddrW-1:0] trap_addr,
  input  logic             irq_req,
  input  logic [AddrW-1:0] irq_addr,
  output logic             valid,
  output logic [AddrW-1:0] addr,
  output redir_src_e       src
);

  always_comb begin
    valid = 1'b0;
    addr  = '0;
    src   = SrcNone;
    if (trap_req) begin
      valid = 1'b1;
      addr  = trap_addr;
      src   = SrcTrap;
    end else if (jump_en) begin
      valid = 1'b1;
      addr  = jump_addr;
      src   = SrcJump;
    end else if (irq_req) begin
      valid = 1'b1;
      addr  = irq_addr;
      src   = SrcIrq;
    end
  end

endmodule

// File: rtl/pipe_redirect_arb.sv
// Pipeline redirect/stall arbiter: picks one redirect, issues a registered PC redirect pulse,
// then drains with flushes. Interrupt path enabled by defining CTRL_IRQ_EN.
module pipe_redirect_arb
  import pipe_redirect_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_addr_i,
  output logic              irq_ack_o,
  input  logic              hold_id_i,
  input  logic              hold_mem_i,
  output logic              redirect_en_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic [1:0]        redirect_src_o,
  output logic              stall_pc_o,
  output logic              stall_if_id_o,
  output logic              stall_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o
);

  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  redir_src_e        pend_src_q, pend_src_d;

  logic              en_q, en_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  redir_src_e        src_q, src_d;

  logic              irq_gated;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  redir_src_e        sel_src;

`ifdef CTRL_IRQ_EN
  // Interrupts only at an instruction boundary: plain RUN, no hazard, no bus wait.
  assign irq_gated = irq_req_i & (state_q == StRun) & ~hold_id_i & ~hold_mem_i;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_req_i, irq_addr_i};
  assign irq_gated  = 1'b0;
`endif

  pipe_redirect_arb_prio_sel #(
    .AddrW (ADDR_W)
  ) u_prio_sel (
    .jump_en   (jump_en_i),
    .jump_addr (jump_addr_i),
    .trap_req  (trap_req_i),
    .trap_addr (trap_addr_i),
    .irq_req   (irq_gated),
    .irq_addr  (irq_addr_i),
    .valid     (sel_valid),
    .addr      (sel_addr),
    .src       (sel_src)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    pend_src_d    = pend_src_q;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    case (state_q)
      StRun: begin
        if (sel_valid) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = sel_addr;
          pend_src_d   = sel_src;
        end
        if (hold_mem_i) begin
          state_d = StHold;
        end else if (sel_valid) begin
          state_d = StIssue;
        end else if (hold_id_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end
      StHold: begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
        if (sel_valid && (!pend_valid_q || (src_rank(sel_src) > src_rank(pend_src_q)))) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = sel_addr;
          pend_src_d   = sel_src;
        end
        if (!hold_mem_i) begin
          state_d = pend_valid_d ? StIssue : StRun;
        end
      end
      StIssue: begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        pend_valid_d  = 1'b0;
        cnt_d         = DrainLoad;
        state_d       = (DRAIN_CYCLES <= 1) ? StRun : StDrain;
      end
      StDrain: begin
        // Requests here come from squashed instructions and are dropped.
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (hold_mem_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Redirect outputs are registered; the target holds between pulses.
  always_comb begin
    en_d   = 1'b0;
    ack_d  = 1'b0;
    addr_d = addr_q;
    src_d  = SrcNone;
    if (state_d == StIssue) begin
      en_d   = 1'b1;
      addr_d = pend_addr_d;
      src_d  = pend_src_d;
      ack_d  = (pend_src_d == SrcIrq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_src_q   <= SrcNone;
      en_q         <= 1'b0;
      ack_q        <= 1'b0;
      addr_q       <= '0;
      src_q        <= SrcNone;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_src_q   <= pend_src_d;
      en_q         <= en_d;
      ack_q        <= ack_d;
      addr_q       <= addr_d;
      src_q        <= src_d;
    end
  end

  assign redirect_en_o   = en_q;
  assign redirect_addr_o = addr_q;
  assign redirect_src_o  = src_q;
  assign irq_ack_o       = ack_q;

endmodule

// File: tb/tb_pipe_redirect_arb.sv
// Scoreboard bench for pipe_redirect_arb: expected redirects are queued at stimulus time
// and popped when the DUT pulses redirect_en_o.
module tb_pipe_redirect_arb;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i, trap_req_i, irq_req_i, hold_id_i, hold_mem_i;
  logic [31:0] jump_addr_i, trap_addr_i, irq_addr_i;
  logic        irq_ack_o, redirect_en_o;
  logic [31:0] redirect_addr_o;
  logic [1:0]  redirect_src_o;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acks   = 0;
  int   exp_acks = 0;

  always #5 clk = ~clk;

  pipe_redirect_arb #(
    .ADDR_W       (32),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .jump_en_i       (jump_en_i),
    .jump_addr_i     (jump_addr_i),
    .trap_req_i      (trap_req_i),
    .trap_addr_i     (trap_addr_i),
    .irq_req_i       (irq_req_i),
    .irq_addr_i      (irq_addr_i),
    .irq_ack_o       (irq_ack_o),
    .hold_id_i       (hold_id_i),
    .hold_mem_i      (hold_mem_i),
    .redirect_en_o   (redirect_en_o),
    .redirect_addr_o (redirect_addr_o),
    .redirect_src_o  (redirect_src_o),
    .stall_pc_o      (stall_pc_o),
    .stall_if_id_o   (stall_if_id_o),
    .stall_id_ex_o   (stall_id_ex_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {en, src, ack, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
  function automatic logic [8:0] ctl();
    return {redirect_en_o, redirect_src_o, irq_ack_o, stall_pc_o, stall_if_id_o,
            stall_id_ex_o, flush_if_id_o, flush_id_ex_o};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jump_en_i  = 1'b0; jump_addr_i = '0;
    trap_req_i = 1'b0; trap_addr_i = '0;
    irq_req_i  = 1'b0; irq_addr_i  = '0;
    hold_id_i  = 1'b0; hold_mem_i  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (irq_ack_o) n_acks++;
      if (irq_ack_o && !redirect_en_o) check_eq("ack_no_redir", 64'(redirect_en_o), 64'd1);
      if (redirect_en_o) begin
        if (sb.size() == 0) begin
          check_eq("unexp_redir", 64'(redirect_addr_o), 64'hffff_ffff_ffff_ffff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("redir_addr", 64'(redirect_addr_o), 64'(e.addr));
          check_eq("redir_src", 64'(redirect_src_o), 64'(e.src));
          check_eq("redir_flush", 64'({flush_if_id_o, flush_id_ex_o}), 64'd3);
          check_eq("redir_ack", 64'(irq_ack_o), 64'(e.src == 2'd3));
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ctl", 64'(ctl()), 64'd0);
    check_eq("rst_addr", 64'(redirect_addr_o), 64'd0);
    repeat (2) next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Jump: issue next cycle, one extra drain cycle, then quiet.
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    sb.push_back('{addr: 32'h100, src: 2'd1});
    @(negedge clk) check_eq("jmp_req_ctl", 64'(ctl()), 64'd0);
    next_cyc(); idle();
    @(negedge clk) check_eq("jmp_issue_ctl", 64'(ctl()), 64'b1_01_0_000_11);
    next_cyc();
    @(negedge clk) check_eq("jmp_drain_ctl", 64'(ctl()), 64'b0_00_0_000_11);
    next_cyc();
    @(negedge clk) check_eq("jmp_done_ctl", 64'(ctl()), 64'd0);
    check_eq("jmp_addr_hold", 64'(redirect_addr_o), 64'h100);
    next_cyc();

    // Trap and jump together: only the trap issues.
    trap_req_i = 1'b1; trap_addr_i = 32'h80; jump_en_i = 1'b1; jump_addr_i = 32'h200;
    sb.push_back('{addr: 32'h80, src: 2'd2});
    next_cyc(); idle();
    repeat (4) next_cyc();

    // Bus hold with jump then trap pending; a later jump must not displace the trap.
    hold_mem_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h300;
    @(negedge clk) check_eq("hold_c1_en", 64'(redirect_en_o), 64'd0);
    next_cyc();
    jump_en_i = 1'b0; trap_req_i = 1'b1; trap_addr_i = 32'h80;
    @(negedge clk) check_eq("hold_c2_ctl", 64'(ctl()), 64'b0_00_0_111_00);
    next_cyc();
    trap_req_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h400;
    @(negedge clk) check_eq("hold_c3_ctl", 64'(ctl()), 64'b0_00_0_111_00);
    next_cyc();
    idle();
    sb.push_back('{addr: 32'h80, src: 2'd2});
    @(negedge clk) check_eq("hold_c4_ctl", 64'(ctl()), 64'b0_00_0_111_00);
    next_cyc();
    @(negedge clk) check_eq("hold_issue_en", 64'(redirect_en_o), 64'd1);
    repeat (3) next_cyc();

    // Load-use hazard alone, then with a jump (jump wins).
    hold_id_i = 1'b1;
    @(negedge clk) check_eq("hid_ctl", 64'(ctl()), 64'b0_00_0_110_01);
    next_cyc();
    @(negedge clk) check_eq("hid_ctl2", 64'(ctl()), 64'b0_00_0_110_01);
    jump_en_i = 1'b1; jump_addr_i = 32'h500;
    #1 check_eq("hid_jmp_ctl", 64'(ctl()), 64'd0);
    sb.push_back('{addr: 32'h500, src: 2'd1});
    next_cyc(); idle();
    repeat (3) next_cyc();

    // Bus hold during drain freezes the counter; requests in drain are dropped.
    jump_en_i = 1'b1; jump_addr_i = 32'h600;
    sb.push_back('{addr: 32'h600, src: 2'd1});
    next_cyc(); idle();
    next_cyc();
    hold_mem_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h700;
    @(negedge clk) check_eq("drain_hold1", 64'(ctl()), 64'b0_00_0_111_11);
    next_cyc();
    jump_en_i = 1'b0;
    @(negedge clk) check_eq("drain_hold2", 64'(ctl()), 64'b0_00_0_111_11);
    next_cyc();
    hold_mem_i = 1'b0;
    @(negedge clk) check_eq("drain_last", 64'(ctl()), 64'b0_00_0_000_11);
    next_cyc();
    @(negedge clk) check_eq("drain_done", 64'(ctl()), 64'd0);
    repeat (2) next_cyc();

    // Interrupt held while blocked by a load-use hazard.
    irq_req_i = 1'b1; irq_addr_i = 32'h40; hold_id_i = 1'b1;
    @(negedge clk) check_eq("irq_blk_ack", 64'(irq_ack_o), 64'd0);
    next_cyc();
    @(negedge clk) check_eq("irq_blk_ack2", 64'(irq_ack_o), 64'd0);
    next_cyc();
    hold_id_i = 1'b0;
`ifdef CTRL_IRQ_EN
    sb.push_back('{addr: 32'h40, src: 2'd3});
    exp_acks = 1;
    next_cyc();
    irq_req_i = 1'b0;
    @(negedge clk) check_eq("irq_ack", 64'(irq_ack_o), 64'd1);
`else
    next_cyc();
    @(negedge clk) check_eq("irq_off_ack", 64'(irq_ack_o), 64'd0);
    repeat (2) next_cyc();
`endif
    idle();
    repeat (4) next_cyc();

    // Reset mid-drain.
    jump_en_i = 1'b1; jump_addr_i = 32'h900;
    sb.push_back('{addr: 32'h900, src: 2'd1});
    next_cyc(); idle();
    next_cyc();
    rst_n = 1'b0;
    #1 check_eq("rst_drain_ctl", 64'(ctl()), 64'd0);
    check_eq("rst_drain_addr", 64'(redirect_addr_o), 64'd0);
    next_cyc();
    rst_n = 1'b1;
    repeat (4) next_cyc();

    // Reset mid-hold with the pending slot full; nothing stale may issue afterwards.
    hold_mem_i = 1'b1; trap_req_i = 1'b1; trap_addr_i = 32'ha00;
    next_cyc(); idle(); hold_mem_i = 1'b1;
    @(negedge clk) check_eq("pre_rst_hold", 64'(stall_pc_o), 64'd1);
    rst_n = 1'b0;
    #1 check_eq("rst_hold_ctl", 64'(ctl()), 64'd0);
    next_cyc();
    hold_mem_i = 1'b0;
    rst_n = 1'b1;
    repeat (5) next_cyc();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    check_eq("ack_count", 64'(n_acks), 64'(exp_acks));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
